weight_loader: RTL and testbench

- Sequencer directly upstream of the CNN register bank: takes a kernel's weights as a byte stream on a valid/ready handshake.
- Drives the shared register data bus and one active-low load strobe per register, filling NUM_REGS registers in index order.
- Signals completion so the convolution datapath can start.
- Output drive matches the register stage: data on a shared bus, load active-low, registers sample on the rising clock edge.

---
 rtl/weight_loader.sv | 94 +++++++++
 tb/tb_weight_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Kernel weight sequencer: accepts a byte stream and drives the register
// bank's shared data bus plus one active-low load strobe per register.
module weight_loader #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_REGS      = 9,
    parameter int IDX_WIDTH     = 4
) (
    input  logic                     WeightLoader_CLOCK,
    input  logic                     WeightLoader_Reset_InHigh,
    input  logic                     WeightLoader_Start_InHigh,
    input  logic                     WeightLoader_Abort_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] WeightLoader_DataInBUS,
    input  logic                     WeightLoader_DataValid_InHigh,
    output logic                     WeightLoader_DataReady_OutHigh,
    output logic [DATAWIDTH_BUS-1:0] WeightLoader_DataOutBUS,
    output logic [NUM_REGS-1:0]      WeightLoader_LoadBUS_InLow,
    output logic [IDX_WIDTH-1:0]     WeightLoader_Index_OutBUS,
    output logic                     WeightLoader_Busy_OutHigh,
    output logic                     WeightLoader_Done_OutHigh
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LP_LAST = IDX_WIDTH'(NUM_REGS - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IDX_WIDTH-1:0]     r_index;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic [NUM_REGS-1:0]      r_load_n;
    logic [NUM_REGS-1:0]      w_strobe_n;
    logic                     w_ready;
    logic                     w_hs;
    logic                     w_last;

    always_comb begin
        w_ready      = (r_state == S_LOAD) && !WeightLoader_Abort_InHigh;
        w_hs         = w_ready && WeightLoader_DataValid_InHigh;
        w_last       = (r_index == LP_LAST);
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (WeightLoader_Start_InHigh) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (WeightLoader_Abort_InHigh) w_state_next = S_IDLE;
                else if (w_hs && w_last)       w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-hot-low strobe selecting the register at the current index
    always_comb begin
        w_strobe_n = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_strobe_n[i] = (r_index != IDX_WIDTH'(i));
        end
    end

    always_ff @(posedge WeightLoader_CLOCK or posedge WeightLoader_Reset_InHigh) begin
        if (WeightLoader_Reset_InHigh) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_data   <= '0;
            r_load_n <= '1;
        end else begin
            r_state  <= w_state_next;
            r_load_n <= '1;
            if (w_hs) begin
                r_data   <= WeightLoader_DataInBUS;
                r_load_n <= w_strobe_n;
                r_index  <= w_last ? '0 : r_index + IDX_WIDTH'(1);
            end else if (r_state == S_IDLE && WeightLoader_Start_InHigh) begin
                r_index <= '0;
            end else if (r_state == S_LOAD && WeightLoader_Abort_InHigh) begin
                r_index <= '0;
            end
        end
    end

    assign WeightLoader_DataReady_OutHigh = w_ready;
    assign WeightLoader_DataOutBUS        = r_data;
    assign WeightLoader_LoadBUS_InLow     = r_load_n;
    assign WeightLoader_Index_OutBUS      = r_index;
    assign WeightLoader_Busy_OutHigh      = (r_state != S_IDLE);
    assign WeightLoader_Done_OutHigh      = (r_state == S_DONE);

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader with a stream-level reference model
// and a model of the downstream register bank.
module tb_weight_loader;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int VW = 3 + IW + N + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ready;
    logic [DW-1:0] dout;
    logic [N-1:0]  load_n;
    logic [IW-1:0] index;
    logic          busy;
    logic          done;
    logic [VW-1:0] w_vec;

    weight_loader #(.DATAWIDTH_BUS(DW), .NUM_REGS(N), .IDX_WIDTH(IW)) dut (
        .WeightLoader_CLOCK            (clk),
        .WeightLoader_Reset_InHigh     (rst),
        .WeightLoader_Start_InHigh     (start),
        .WeightLoader_Abort_InHigh     (abort),
        .WeightLoader_DataInBUS        (din),
        .WeightLoader_DataValid_InHigh (valid),
        .WeightLoader_DataReady_OutHigh(ready),
        .WeightLoader_DataOutBUS       (dout),
        .WeightLoader_LoadBUS_InLow    (load_n),
        .WeightLoader_Index_OutBUS     (index),
        .WeightLoader_Busy_OutHigh     (busy),
        .WeightLoader_Done_OutHigh     (done)
    );

    always #5 clk = ~clk;

    assign w_vec = {ready, busy, done, index, load_n, dout};

    // Downstream register bank: captures the bus on a low strobe
    logic [DW-1:0] bank [N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!load_n[i]) bank[i] <= dout;
        end
    end

    // Stream-level reference model
    bit            m_loading;
    bit            m_done_now;
    int            m_cnt;
    int            m_strobe;
    logic [DW-1:0] m_last;
    logic [DW-1:0] exp_regs [N];

    int n_pass = 0;
    int n_total = 0;
    int done_seen;
    int strobes_seen;

    function automatic void model_reset();
        m_loading  = 1'b0;
        m_done_now = 1'b0;
        m_cnt      = 0;
        m_strobe   = -1;
        m_last     = '0;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input logic a);
        logic [N-1:0] ld;
        ld = '1;
        if (m_strobe >= 0) ld[m_strobe] = 1'b0;
        return {m_loading && !a, m_loading || m_done_now, m_done_now,
                IW'(m_cnt), ld, m_last};
    endfunction

    function automatic void model_edge();
        bit hs;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_strobe >= 0) exp_regs[m_strobe] = m_last;
        hs = m_loading && !abort && valid;
        m_strobe = -1;
        if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (!m_loading) begin
            if (start) begin
                m_loading = 1'b1;
                m_cnt = 0;
            end
        end else if (abort) begin
            m_loading = 1'b0;
            m_cnt = 0;
        end else if (hs) begin
            m_last = din;
            m_strobe = m_cnt;
            m_cnt++;
            if (m_cnt == N) begin
                m_cnt = 0;
                m_loading = 1'b0;
                m_done_now = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic s, input logic a, input logic v,
                         input logic [DW-1:0] d);
        @(negedge clk);
        start = s;
        abort = a;
        valid = v;
        din   = d;
        #1;
    endtask

    task automatic tick();
        if (done) done_seen++;
        if (load_n != '1) strobes_seen++;
        @(posedge clk);
        model_edge();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 0; abort = 0; valid = 0; din = '0;
        #1;
        model_reset();
        n_total++;
        if (load_n !== 9'h1FF) $display("FAIL reset_load got %h want 1ff", load_n);
        else n_pass++;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 1, 8'hA5);
            n_total++;
            if (w_vec !== exp_vec(abort))
                $display("FAIL reset_idle c%0d got %h want %h", c, w_vec, exp_vec(abort));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        done_seen = 0;
        strobes_seen = 0;
        drive(1, 0, 0, 8'h00);
        tick();
        for (int b = 1; b <= N + 3; b++) begin
            if (b <= N) drive(0, 0, 1, 8'(b));
            else drive(0, 0, 0, 8'h00);
            n_total++;
            if (w_vec !== exp_vec(abort))
                $display("FAIL b2b c%0d got %h want %h", b, w_vec, exp_vec(abort));
            else n_pass++;
            tick();
        end
        n_total++;
        if (done_seen !== 1 || strobes_seen !== N)
            $display("FAIL b2b_counts got done=%0d strobes=%0d want 1/%0d",
                     done_seen, strobes_seen, N);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (bank[i] !== 8'(i + 1))
                $display("FAIL b2b_reg%0d got %h want %h", i, bank[i], 8'(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        done_seen = 0;
        drive(1, 0, 0, 8'h00);
        tick();
        for (int c = 0; c < N + 5; c++) begin
            if (c == 3 || c == 7 || c >= N + 2) drive(0, 0, 0, 8'($urandom));
            else drive(0, 0, 1, 8'($urandom));
            n_total++;
            if (w_vec !== exp_vec(abort))
                $display("FAIL gaps c%0d got %h want %h", c, w_vec, exp_vec(abort));
            else n_pass++;
            if (c == 4 || c == 8) begin
                n_total++;
                if (load_n !== 9'h1FF || index !== IW'(c == 4 ? 3 : 6))
                    $display("FAIL gaps_hold c%0d got load=%h idx=%0d", c, load_n, index);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (done_seen !== 1) $display("FAIL gaps_done got %0d want 1", done_seen);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (bank[i] !== exp_regs[i])
                $display("FAIL gaps_reg%0d got %h want %h", i, bank[i], exp_regs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] snap [N];
        for (int i = 0; i < N; i++) snap[i] = exp_regs[i];
        done_seen = 0;
        drive(1, 0, 0, 8'h00);
        tick();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(0, 0, 1, ~snap[c]);
            else if (c == 4) drive(0, 1, 1, ~snap[4]);
            else drive(0, 0, 1, 8'($urandom));
            n_total++;
            if (w_vec !== exp_vec(abort))
                $display("FAIL abort c%0d got %h want %h", c, w_vec, exp_vec(abort));
            else n_pass++;
            if (c == 4) begin
                n_total++;
                if (ready !== 1'b0 || index !== IW'(4))
                    $display("FAIL abort_ready got rdy=%b idx=%0d want 0/4", ready, index);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (done_seen !== 0 || busy !== 1'b0 || index !== '0)
            $display("FAIL abort_idle got done=%0d busy=%b idx=%0d", done_seen, busy, index);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (bank[i] !== (i < 4 ? ~snap[i] : snap[i]))
                $display("FAIL abort_reg%0d got %h want %h", i, bank[i],
                         i < 4 ? ~snap[i] : snap[i]);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        done_seen = 0;
        strobes_seen = 0;
        drive(1, 0, 0, 8'h00);
        tick();
        for (int c = 0; c < 40; c++) begin
            if (m_cnt == 2 && m_loading) drive(1, 0, 1, 8'($urandom));
            else drive(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
            n_total++;
            if (w_vec !== exp_vec(abort))
                $display("FAIL restart c%0d got %h want %h", c, w_vec, exp_vec(abort));
            else n_pass++;
            tick();
            if (!m_loading && !m_done_now && m_strobe < 0) break;
        end
        n_total++;
        if (done_seen !== 1 || strobes_seen !== N)
            $display("FAIL restart_counts got done=%0d strobes=%0d want 1/%0d",
                     done_seen, strobes_seen, N);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom));
            n_total++;
            if (w_vec !== exp_vec(abort) || $countones(~load_n) > 1)
                $display("FAIL random c%0d got %h want %h", c, w_vec, exp_vec(abort));
            else n_pass++;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 8'h00);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (bank[i] !== exp_regs[i])
                $display("FAIL random_reg%0d got %h want %h", i, bank[i], exp_regs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] snap4;
        snap4 = exp_regs[4];
        drive(1, 0, 0, 8'h00);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 1, c == 4 ? ~snap4 : 8'($urandom));
            tick();
        end
        drive(0, 0, 0, 8'h00);
        n_total++;
        if (load_n !== 9'h1EF || w_vec !== exp_vec(abort))
            $display("FAIL areset_pre got %h want %h", w_vec, exp_vec(abort));
        else n_pass++;
        rst = 1'b1;
        #1;
        model_reset();
        n_total++;
        if (load_n !== 9'h1FF || busy !== 1'b0 || index !== '0 || dout !== '0)
            $display("FAIL areset_now got load=%h busy=%b idx=%0d data=%h",
                     load_n, busy, index, dout);
        else n_pass++;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        n_total++;
        if (bank[4] !== snap4 || busy !== 1'b0)
            $display("FAIL areset_reg4 got %h want %h", bank[4], snap4);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (bank[i] !== exp_regs[i])
                $display("FAIL areset_reg%0d got %h want %h", i, bank[i], exp_regs[i]);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_start_ignored();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
